// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared states, character codes and word geometry for the UART program loader
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_RUN_HOLD,
        ST_ACK
    } state_t;

    localparam logic [7:0] CH_G   = 8'h47;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_H   = 8'h48;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_ACK = 8'h2B;
    localparam logic [7:0] CH_NAK = 8'h21;

    localparam int NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/uart_prog_loader_hex_decode.sv
// rtl/uart_prog_loader_hex_decode.sv - combinational ASCII hex digit / whitespace classifier
module hex_ascii_decode
    import uart_loader_pkg::*;
(
    input  logic [7:0] data,    // received byte
    output logic       is_hex,  // byte is 0-9, A-F or a-f
    output logic [3:0] nibble,  // value of the hex digit, 0 when not hex
    output logic       is_ws    // byte is CR, LF or space
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        is_ws  = (data == CH_CR) || (data == CH_LF) || (data == CH_SP);
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data[3:0];
        end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - ASCII hex program loader and CPU run sequencer; UART_LOADER_WORD_ACK_EN adds per-word '+'/'!' acks
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // UART receive side
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr,
    // UART transmit side
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    // instruction memory write port
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    // CPU sequencing and status
    input  logic              cpu_halted,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              err
);

    localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [3:0]      LAST_NIB = 4'(NIBBLES_PER_WORD - 1);

    state_t          state;
    logic [31:0]     acc;
    logic [3:0]      nib_cnt;
    logic [ADDR_W:0] wr_ptr;
    logic            halt_sent;
    logic            halt_pend;
    logic            halted_q;
`ifdef UART_LOADER_WORD_ACK_EN
    logic            ack_pend;
    logic [7:0]      ack_char;
`endif

    logic       is_hex;
    logic       is_ws;
    logic [3:0] nibble;
    logic       accept;
    logic [31:0] acc_next;

    hex_ascii_decode u_decode (
        .data   (rx_data),
        .is_hex (is_hex),
        .nibble (nibble),
        .is_ws  (is_ws)
    );

    assign accept     = rx_rdy && !tx_busy;
    assign acc_next   = (acc << 4) | {28'd0, nibble};
    // wr_ptr never passes WORDS, so it doubles as the saturating word count
    assign load_count = wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            acc       <= 32'd0;
            nib_cnt   <= 4'd0;
            wr_ptr    <= '0;
            halt_sent <= 1'b0;
            halt_pend <= 1'b0;
            halted_q  <= 1'b0;
            rx_clr    <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_run   <= 1'b0;
            err       <= 1'b0;
`ifdef UART_LOADER_WORD_ACK_EN
            ack_pend  <= 1'b0;
            ack_char  <= 8'd0;
`endif
        end else begin
            rx_clr   <= 1'b0;
            tx_wr    <= 1'b0;
            mem_we   <= 1'b0;
            halted_q <= cpu_halted;
            if (cpu_halted && !halted_q && cpu_run && !halt_sent)
                halt_pend <= 1'b1;

            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        rx_clr  <= 1'b1;
                        tx_wr   <= 1'b1;
                        tx_data <= rx_data;
                        state   <= ST_HOLD;
                        if (is_hex) begin
                            acc <= acc_next;
                            if (nib_cnt == LAST_NIB) begin
                                nib_cnt <= 4'd0;
                                if (wr_ptr == FULL) begin
                                    err <= 1'b1;
`ifdef UART_LOADER_WORD_ACK_EN
                                    ack_pend <= 1'b1;
                                    ack_char <= CH_NAK;
`endif
                                end else begin
                                    mem_we    <= 1'b1;
                                    mem_addr  <= wr_ptr[ADDR_W-1:0];
                                    mem_wdata <= acc_next;
                                    wr_ptr    <= wr_ptr + PTR_ONE;
`ifdef UART_LOADER_WORD_ACK_EN
                                    ack_pend <= 1'b1;
                                    ack_char <= CH_ACK;
`endif
                                end
                            end else begin
                                nib_cnt <= nib_cnt + 4'd1;
                            end
                        end else if (rx_data == CH_G) begin
                            if (nib_cnt == 4'd0) begin
                                cpu_run   <= 1'b1;
                                halt_sent <= 1'b0;
                                halt_pend <= 1'b0;
                            end else begin
                                err     <= 1'b1;
                                nib_cnt <= 4'd0;
                                acc     <= 32'd0;
                            end
                        end else if (rx_data == CH_R) begin
                            wr_ptr  <= '0;
                            nib_cnt <= 4'd0;
                            acc     <= 32'd0;
                            err     <= 1'b0;
                        end else if (!is_ws) begin
                            err     <= 1'b1;
                            nib_cnt <= 4'd0;
                            acc     <= 32'd0;
                        end
                    end
                end

                // rx_rdy is still high here while the receiver clears, so it is ignored
                ST_HOLD: begin
`ifdef UART_LOADER_WORD_ACK_EN
                    if (ack_pend)
                        state <= ST_ACK;
                    else
`endif
                    state <= cpu_run ? ST_RUN : ST_LOAD;
                end

                ST_RUN: begin
                    // the halt report wins; a pending byte simply waits
                    if (halt_pend && !tx_busy) begin
                        tx_wr     <= 1'b1;
                        tx_data   <= CH_H;
                        halt_sent <= 1'b1;
                        halt_pend <= 1'b0;
                        state     <= ST_RUN_HOLD;
                    end else if (accept) begin
                        rx_clr  <= 1'b1;
                        tx_wr   <= 1'b1;
                        tx_data <= rx_data;
                        state   <= ST_RUN_HOLD;
                        if (rx_data == CH_R) begin
                            cpu_run <= 1'b0;
                            wr_ptr  <= '0;
                            nib_cnt <= 4'd0;
                            acc     <= 32'd0;
                            err     <= 1'b0;
                        end
                    end
                end

                ST_RUN_HOLD: begin
                    state <= cpu_run ? ST_RUN : ST_LOAD;
                end

`ifdef UART_LOADER_WORD_ACK_EN
                ST_ACK: begin
                    if (!tx_busy) begin
                        tx_wr    <= 1'b1;
                        tx_data  <= ack_char;
                        ack_pend <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
`endif

                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader
module tb_uart_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_clr;
    logic        tx_busy;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_halted;
    logic        cpu_run;
    logic [4:0]  load_count;
    logic        err;

    always #5 clk = ~clk;

    uart_prog_loader #(.WORDS(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_clr     (rx_clr),
        .tx_busy    (tx_busy),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_halted (cpu_halted),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;
    int n_tx   = 0;
    int n_clr  = 0;

    logic [7:0]  exp_tx[$];
    logic [35:0] exp_mem[$];
    logic [7:0]  rx_q[$];
    logic        clr_pend = 1'b0;

    // one clock: score DUT outputs, then model a receiver that drops the byte one cycle after rx_clr
    task automatic tick();
        logic [7:0]  et;
        logic [35:0] em;
        @(posedge clk);
        #1;
        if (tx_wr === 1'b1) begin
            n_tx++;
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %h expected none", tx_data);
            end else begin
                et = exp_tx.pop_front();
                if (tx_data !== et) begin
                    errors++;
                    $display("FAIL tx_byte got %h expected %h", tx_data, et);
                end
            end
        end
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected got addr %h data %h expected none", mem_addr, mem_wdata);
            end else begin
                em = exp_mem.pop_front();
                if ({mem_addr, mem_wdata} !== em) begin
                    errors++;
                    $display("FAIL mem_write got %h_%h expected %h_%h", mem_addr, mem_wdata, em[35:32], em[31:0]);
                end
            end
            checks++;
            if (cpu_run !== 1'b0) begin
                errors++;
                $display("FAIL write_while_run got cpu_run %b expected 0", cpu_run);
            end
        end
        if (rx_clr === 1'b1) n_clr++;
        if (clr_pend) begin
            rx_rdy   = 1'b0;
            clr_pend = 1'b0;
        end
        if (rx_clr === 1'b1) clr_pend = 1'b1;
        if (!rx_rdy && rx_q.size() > 0) begin
            rx_data = rx_q.pop_front();
            rx_rdy  = 1'b1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_q.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rx_q.size() > 0 || rx_rdy || clr_pend) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending bytes expected 0", rx_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
        drain();
    endtask

    task automatic bus_reset();
        rst = 1'b1;
        rx_q.delete();
        rx_rdy   = 1'b0;
        clr_pend = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rx_data    = 8'd0;
        tx_busy    = 1'b0;
        cpu_halted = 1'b0;
        rx_rdy     = 1'b0;
        bus_reset();
        checks++;
        if ({rx_clr, tx_wr, tx_data, mem_we, mem_addr, mem_wdata} !== 47'd0) begin
            errors++;
            $display("FAIL reset_datapath got %h expected 0", {rx_clr, tx_wr, tx_data, mem_we, mem_addr, mem_wdata});
        end
        checks++;
        if ({cpu_run, load_count, err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_status got %b expected 0", {cpu_run, load_count, err});
        end
        tick();
    endtask

    task automatic test_load_word();
        int t0;
        t0 = n_tx;
        exp_mem.push_back({4'd0, 32'h00500093});
        send("00500093");
        checks++;
        if (n_tx - t0 != 8) begin
            errors++;
            $display("FAIL echo_count got %0d expected 8", n_tx - t0);
        end
        checks++;
        if (load_count !== 5'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL first_word_status got count %0d err %b expected 1 0", load_count, err);
        end
    endtask

    task automatic test_hex_case();
        exp_mem.push_back({4'd0, 32'hDEADBEEF});
        exp_mem.push_back({4'd1, 32'hDEADBEEF});
        send("Rdeadbeef\r\nDEADBEEF ");
        checks++;
        if (load_count !== 5'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL hex_case_status got count %0d err %b expected 2 0", load_count, err);
        end
    endtask

    task automatic test_full();
        logic [31:0] w;
        send("R");
        for (int i = 0; i < 16; i++) begin
            w = 32'h01234567 ^ (i * 32'h11111111);
            exp_mem.push_back({4'(i), w});
            send($sformatf("%08x", w));
        end
        send("89abcdef");
        checks++;
        if (load_count !== 5'd16 || err !== 1'b1) begin
            errors++;
            $display("FAIL full_drop got count %0d err %b expected 16 1", load_count, err);
        end
    endtask

    task automatic test_go_halt();
        logic prev_run;
        logic seen;
        int   t0;
        send("R12G");
        checks++;
        if (err !== 1'b1 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL partial_go got err %b run %b expected 1 0", err, cpu_run);
        end
        exp_mem.push_back({4'd0, 32'h00100073});
        send("00100073");
        put(8'h47);
        seen     = 1'b0;
        prev_run = cpu_run;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rx_clr === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (prev_run !== 1'b0 || cpu_run !== 1'b1) begin
                    errors++;
                    $display("FAIL go_latency got %b->%b expected 0->1", prev_run, cpu_run);
                end
            end
            prev_run = cpu_run;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL go_accept got no rx_clr expected one");
        end
        drain();
        t0 = n_tx;
        exp_tx.push_back(8'h48);
        cpu_halted = 1'b1;
        repeat (10) tick();
        cpu_halted = 1'b0;
        repeat (2) tick();
        cpu_halted = 1'b1;
        repeat (6) tick();
        cpu_halted = 1'b0;
        checks++;
        if (n_tx - t0 != 1) begin
            errors++;
            $display("FAIL halt_report got %0d tx expected 1", n_tx - t0);
        end
    endtask

    task automatic test_busy_hold();
        int c0, t0;
        c0 = n_clr;
        t0 = n_tx;
        tx_busy = 1'b1;
        put(8'h5A);
        repeat (20) tick();
        checks++;
        if (n_clr != c0 || n_tx != t0) begin
            errors++;
            $display("FAIL busy_stall got clr %0d tx %0d expected 0 0", n_clr - c0, n_tx - t0);
        end
        tx_busy = 1'b0;
        drain();
        checks++;
        if (n_clr - c0 != 1 || n_tx - t0 != 1) begin
            errors++;
            $display("FAIL busy_release got clr %0d tx %0d expected 1 1", n_clr - c0, n_tx - t0);
        end
    endtask

    task automatic test_run_reset();
        logic seen;
        put(8'h52);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rx_clr === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (cpu_run !== 1'b0) begin
                    errors++;
                    $display("FAIL run_stop got %b expected 0", cpu_run);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_r_accept got no rx_clr expected one");
        end
        drain();
        checks++;
        if (load_count !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL run_r_clear got count %0d err %b expected 0 0", load_count, err);
        end
        send("12345");
        bus_reset();
        tick();
        exp_mem.push_back({4'd0, 32'hCAFEF00D});
        send("CAFEF00D");
        checks++;
        if (load_count !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_count got %0d expected 1", load_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_hex_case();
        test_full();
        test_go_halt();
        test_busy_hold();
        test_run_reset();
        checks++;
        if (exp_tx.size() != 0 || exp_mem.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got tx %0d mem %0d expected 0 0", exp_tx.size(), exp_mem.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
